// File: rtl/diablo_rf_pkg.sv
// Shared definitions for the diablo multi-port register file.
// Holds the default address width, the hardwired zero-register index,
// and a one-hot decoder used to build per-register write and issue masks.
package diablo_rf_pkg;

  localparam int AW_DEF    = 5;
  localparam int MAX_NREGS = 256;
  localparam int ZERO_REG  = '0;

  typedef logic [AW_DEF-1:0] regaddr_t;

  // Returns a mask with only bit 'addr' set; callers keep the low NREGS bits.
  function automatic logic [MAX_NREGS-1:0] onehot_dec(input int unsigned addr);
    logic [MAX_NREGS-1:0] mask;
    mask = {{(MAX_NREGS-1){1'b0}}, 1'b1} << addr;
    return mask;
  endfunction

endpackage

// File: rtl/diablo_rf_scoreboard.sv
// Busy scoreboard for the diablo register file.
// One busy bit per architectural register. At each edge a flush clears
// everything; otherwise an issue sets its destination and wins over a
// writeback clear to the same register. Register 0 is never busy.
module diablo_rf_scoreboard #(
  parameter  int NREGS = 32,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  output logic [NREGS-1:0]  busy
);
  import diablo_rf_pkg::*;

  logic [NREGS-1:0]     set_mask;
  logic [NREGS-1:0]     clr_mask;
  logic [MAX_NREGS-1:0] dec;

  // Build the set mask from the issue port and the clear mask from all write ports.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    dec      = '0;
    if (issue_en && int'(issue_addr) != ZERO_REG) begin
      dec      = onehot_dec(int'(issue_addr));
      set_mask = dec[NREGS-1:0];
    end
    for (int w = 0; w < NWR; w++) begin
      if (wen[w] && int'(waddr[w*AW +: AW]) != ZERO_REG) begin
        dec      = onehot_dec(int'(waddr[w*AW +: AW]));
        clr_mask = clr_mask | dec[NREGS-1:0];
      end
    end
  end

  // Apply flush, then set-over-clear, to the registered busy vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/diablo_regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// x0 reads as zero and is never stored. Reads are combinational; writes land
// on the rising edge with the highest-index port winning on address collision,
// which also raises a one-cycle write_fault_out pulse.
// Optional macro DIABLO_REGFILE_BYPASS_EN forwards same-cycle write data
// (and a cleared busy) to matching read ports.
module diablo_regfile_mp #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr_in,
  output logic [NRD*XLEN-1:0] rdata_out,
  output logic [NRD-1:0]      busy_out,
  input  logic [NWR*AW-1:0]   waddr_in,
  input  logic [NWR*XLEN-1:0] wdata_in,
  input  logic [NWR-1:0]      wen_in,
  input  logic                issue_en_in,
  input  logic [AW-1:0]       issue_addr_in,
  input  logic                flush_in,
  output logic                write_fault_out
);
  import diablo_rf_pkg::*;

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:0] busy;
  logic             fault_next;
  logic [AW-1:0]    rd_addr;

  diablo_rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_in),
    .issue_en   (issue_en_in),
    .issue_addr (issue_addr_in),
    .wen        (wen_in),
    .waddr      (waddr_in),
    .busy       (busy)
  );

  // Flag any pair of enabled write ports targeting the same nonzero register.
  always_comb begin
    fault_next = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wen_in[i] && wen_in[j] &&
            waddr_in[i*AW +: AW] == waddr_in[j*AW +: AW] &&
            int'(waddr_in[i*AW +: AW]) != ZERO_REG) begin
          fault_next = 1'b1;
        end
      end
    end
  end

  // Register storage; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wen_in[w] && int'(waddr_in[w*AW +: AW]) != ZERO_REG) begin
          regs[waddr_in[w*AW +: AW]] <= wdata_in[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Registered one-cycle collision pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_fault_out <= 1'b0;
    end else begin
      write_fault_out <= fault_next;
    end
  end

  // Read muxes: zero for x0 and during reset, optional same-cycle forwarding.
  always_comb begin
    rdata_out = '0;
    busy_out  = '0;
    rd_addr   = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr = raddr_in[p*AW +: AW];
      if (!rst && int'(rd_addr) != ZERO_REG) begin
        rdata_out[p*XLEN +: XLEN] = regs[rd_addr];
        busy_out[p]               = busy[rd_addr];
`ifdef DIABLO_REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wen_in[w] && waddr_in[w*AW +: AW] == rd_addr) begin
            rdata_out[p*XLEN +: XLEN] = wdata_in[w*XLEN +: XLEN];
            busy_out[p]               = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_diablo_regfile_mp.sv
// Self-checking bench for diablo_regfile_mp (NREGS=16, XLEN=32, NRD=3, NWR=2).
// A behavioural model of the architectural registers, busy bits and fault
// pulse is checked against the DUT on every falling edge; directed scenarios
// add literal expectations, followed by randomized traffic with occasional
// asynchronous resets.
module tb_diablo_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr_in;
  logic [NRD*XLEN-1:0] rdata_out;
  logic [NRD-1:0]      busy_out;
  logic [NWR*AW-1:0]   waddr_in;
  logic [NWR*XLEN-1:0] wdata_in;
  logic [NWR-1:0]      wen_in;
  logic                issue_en_in;
  logic [AW-1:0]       issue_addr_in;
  logic                flush_in;
  logic                write_fault_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [XLEN-1:0] model_regs [NREGS];
  logic            model_busy [NREGS];
  logic            model_fault;

  diablo_regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .raddr_in        (raddr_in),
    .rdata_out       (rdata_out),
    .busy_out        (busy_out),
    .waddr_in        (waddr_in),
    .wdata_in        (wdata_in),
    .wen_in          (wen_in),
    .issue_en_in     (issue_en_in),
    .issue_addr_in   (issue_addr_in),
    .flush_in        (flush_in),
    .write_fault_out (write_fault_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Holds the current inputs across one rising edge, returning just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    wen_in      = '0;
    waddr_in    = '0;
    wdata_in    = '0;
    issue_en_in = 1'b0;
    issue_addr_in = '0;
    flush_in    = 1'b0;
  endtask

  // Architectural model: what each register, busy bit and the fault pulse must hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        model_regs[r] = '0;
        model_busy[r] = 1'b0;
      end
      model_fault = 1'b0;
    end else begin
      int a0, a1;
      a0 = int'(waddr_in[0 +: AW]);
      a1 = int'(waddr_in[AW +: AW]);
      model_fault = wen_in[0] && wen_in[1] && a0 == a1 && a0 != 0;
      if (wen_in[0] && a0 != 0) model_regs[a0] = wdata_in[0 +: XLEN];
      if (wen_in[1] && a1 != 0) model_regs[a1] = wdata_in[XLEN +: XLEN];
      if (flush_in) begin
        for (int r = 0; r < NREGS; r++) model_busy[r] = 1'b0;
      end else begin
        if (wen_in[0] && a0 != 0) model_busy[a0] = 1'b0;
        if (wen_in[1] && a1 != 0) model_busy[a1] = 1'b0;
        if (issue_en_in && issue_addr_in != 0) model_busy[issue_addr_in] = 1'b1;
      end
    end
  end

  // Compare every read port and the fault pulse against the model mid-cycle.
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      int a;
      logic [XLEN-1:0] ed;
      logic eb;
      a  = int'(raddr_in[p*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      if (!rst && a != 0) begin
        ed = model_regs[a];
        eb = model_busy[a];
`ifdef DIABLO_REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wen_in[w] && int'(waddr_in[w*AW +: AW]) == a) begin
            ed = wdata_in[w*XLEN +: XLEN];
            eb = 1'b0;
          end
        end
`endif
      end
      checkOutput($sformatf("rdata_p%0d", p), 64'(rdata_out[p*XLEN +: XLEN]), 64'(ed));
      checkOutput($sformatf("busy_p%0d", p), 64'(busy_out[p]), 64'(eb));
    end
    checkOutput("write_fault", 64'(write_fault_out), 64'(rst ? 1'b0 : model_fault));
  end

  initial begin
    rst = 1'b1;
    raddr_in = '0;
    clearInputs();
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Reset value of a register after power-up reset.
    raddr_in = {4'd0, 4'd0, 4'd5};
    #1;
    checkOutput("reset_rdata_x5", 64'(rdata_out[0 +: XLEN]), 64'h0);

    // Writes to x0 are discarded with no fault.
    wen_in = 2'b01; waddr_in = {4'd0, 4'd0}; wdata_in = {32'h0, 32'hFFFF};
    raddr_in = '0;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("x0_rdata", 64'(rdata_out[0 +: XLEN]), 64'h0);
    checkOutput("x0_busy", 64'(busy_out[0]), 64'h0);
    checkOutput("x0_fault", 64'(write_fault_out), 64'h0);

    // Issue x7, then write it back.
    issue_en_in = 1'b1; issue_addr_in = 4'd7;
    applyStimulus();
    clearInputs();
    raddr_in = {4'd0, 4'd0, 4'd7};
    #1;
    checkOutput("x7_busy_after_issue", 64'(busy_out[0]), 64'h1);
    wen_in = 2'b01; waddr_in = {4'd0, 4'd7}; wdata_in = {32'h0, 32'h1234};
    #1;
`ifdef DIABLO_REGFILE_BYPASS_EN
    checkOutput("x7_busy_wb_cycle", 64'(busy_out[0]), 64'h0);
    checkOutput("x7_rdata_wb_cycle", 64'(rdata_out[0 +: XLEN]), 64'h1234);
`else
    checkOutput("x7_busy_wb_cycle", 64'(busy_out[0]), 64'h1);
    checkOutput("x7_rdata_wb_cycle", 64'(rdata_out[0 +: XLEN]), 64'h0);
`endif
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("x7_busy_after_wb", 64'(busy_out[0]), 64'h0);
    checkOutput("x7_rdata_after_wb", 64'(rdata_out[0 +: XLEN]), 64'h1234);

    // Same-cycle issue and writeback of x9: set wins, data lands.
    issue_en_in = 1'b1; issue_addr_in = 4'd9;
    wen_in = 2'b01; waddr_in = {4'd0, 4'd9}; wdata_in = {32'h0, 32'h55};
    applyStimulus();
    clearInputs();
    raddr_in = {4'd0, 4'd9, 4'd0};
    #1;
    checkOutput("x9_busy", 64'(busy_out[1]), 64'h1);
    checkOutput("x9_rdata", 64'(rdata_out[XLEN +: XLEN]), 64'h55);

    // Both write ports hit x3: port 1 wins, fault pulses for one cycle.
    wen_in = 2'b11; waddr_in = {4'd3, 4'd3}; wdata_in = {32'hB, 32'hA};
    applyStimulus();
    clearInputs();
    raddr_in = {4'd3, 4'd0, 4'd0};
    #1;
    checkOutput("x3_rdata", 64'(rdata_out[2*XLEN +: XLEN]), 64'hB);
    checkOutput("x3_fault_pulse", 64'(write_fault_out), 64'h1);
    applyStimulus();
    #1;
    checkOutput("x3_fault_cleared", 64'(write_fault_out), 64'h0);

    // Issue x4 and x6, then flush alongside an issue of x8.
    issue_en_in = 1'b1; issue_addr_in = 4'd4;
    applyStimulus();
    issue_addr_in = 4'd6;
    applyStimulus();
    raddr_in = {4'd8, 4'd6, 4'd4};
    #1;
    checkOutput("x4_busy_pre_flush", 64'(busy_out[0]), 64'h1);
    checkOutput("x6_busy_pre_flush", 64'(busy_out[1]), 64'h1);
    flush_in = 1'b1; issue_en_in = 1'b1; issue_addr_in = 4'd8;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("x4_busy_flushed", 64'(busy_out[0]), 64'h0);
    checkOutput("x6_busy_flushed", 64'(busy_out[1]), 64'h0);
    checkOutput("x8_busy_flushed", 64'(busy_out[2]), 64'h0);

    // Reset mid-run: populate x5 with busy and a fault, then assert reset between edges.
    wen_in = 2'b11; waddr_in = {4'd5, 4'd5}; wdata_in = {32'hDEAD, 32'hDEAD};
    issue_en_in = 1'b1; issue_addr_in = 4'd5;
    applyStimulus();
    clearInputs();
    raddr_in = {4'd0, 4'd0, 4'd5};
    #1;
    checkOutput("x5_rdata_pre_rst", 64'(rdata_out[0 +: XLEN]), 64'hDEAD);
    checkOutput("x5_busy_pre_rst", 64'(busy_out[0]), 64'h1);
    checkOutput("fault_pre_rst", 64'(write_fault_out), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("x5_rdata_in_rst", 64'(rdata_out[0 +: XLEN]), 64'h0);
    checkOutput("x5_busy_in_rst", 64'(busy_out[0]), 64'h0);
    checkOutput("fault_in_rst", 64'(write_fault_out), 64'h0);
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Randomized traffic with collisions, flushes and occasional async resets.
    for (int c = 0; c < 2000; c++) begin
      wen_in        = 2'($urandom_range(0, 3));
      waddr_in      = 8'($urandom);
      if ($urandom_range(0, 3) == 0) waddr_in[7:4] = waddr_in[3:0];
      wdata_in      = {$urandom, $urandom};
      issue_en_in   = 1'($urandom_range(0, 1));
      issue_addr_in = 4'($urandom);
      flush_in      = ($urandom_range(0, 15) == 0);
      raddr_in      = 12'($urandom);
      applyStimulus();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
      end
    end

    clearInputs();
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
